// File: rtl/fxp_seq_arith_unit.sv
// Sequential saturating Q(INT_W).(FRAC_W) ALU: ADD/SUB/MUL in one execute cycle,
// DIV through a bit-serial restoring divider, then a clip stage and a held result.
module fxp_seq_arith_unit #(
  parameter  int INT_W  = 11,
  parameter  int FRAC_W = 10,
  localparam int W      = INT_W + FRAC_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         sat,
  output logic         dz
);

  localparam int DIV_ITERS = W + FRAC_W;
  localparam int WW        = 2 * W;
  localparam int CNT_W     = $clog2(DIV_ITERS + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic signed [WW-1:0] MAX_WIDE   = {{(WW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_WIDE   = {{(WW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [WW-1:0] ROUND_WIDE = {{(WW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [W-1:0]         MAX_RES    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         MIN_RES    = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0]     LAST_ITER  = CNT_W'(DIV_ITERS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_DIV  = 3'd2,
    S_SAT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Magnitude as unsigned W bits; the most negative value maps to 2**(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    mag = v[W-1] ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Returns {clipped, value} for a wide signed intermediate.
  function automatic logic [W:0] clip(input logic signed [WW-1:0] v);
    if (v > MAX_WIDE) begin
      clip = {1'b1, MAX_RES};
    end else if (v < MIN_WIDE) begin
      clip = {1'b1, MIN_RES};
    end else begin
      clip = {1'b0, v[W-1:0]};
    end
  endfunction

  state_t                 state_r, state_n;
  logic                   in_ready_r, out_valid_r;
  logic [1:0]             op_r;
  logic [W-1:0]           a_r, b_r;
  logic [W-1:0]           result_r;
  logic                   sat_r, dz_r;
  logic signed [WW-1:0]   wide_r;
  logic [W-1:0]           rem_r, div_r;
  logic [DIV_ITERS-1:0]   quo_r;
  logic                   neg_r;
  logic [CNT_W-1:0]       iter_r;

  logic [W:0]             sum_s, diff_s;
  logic signed [WW-1:0]   prod_s, rnd_s, exec_s;
  logic [W:0]             shift_s;
  logic                   ge_s;
  logic [W-1:0]           rem_nxt_s;
  logic [WW-1:0]          quo_ext_s;
  logic signed [WW-1:0]   div_res_s;
  logic [W:0]             clip_s;
  logic                   accept_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign sat       = sat_r;
  assign dz        = dz_r;

  assign accept_s = in_valid & (state_r == S_IDLE);

  // Next-state selection for the operation sequencer.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          state_n = ((op == OP_DIV) && (b != {W{1'b0}})) ? S_DIV : S_EXEC;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_EXEC: state_n = S_SAT;
      S_DIV: begin
        if (iter_r == LAST_ITER) begin
          state_n = S_SAT;
        end else begin
          state_n = S_DIV;
        end
      end
      S_SAT: state_n = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      in_ready_r  <= (state_n == S_IDLE);
      out_valid_r <= (state_n == S_DONE);
    end
  end

  // Single-cycle arithmetic, one divider step and the clip of the wide intermediate.
  always_comb begin
    sum_s  = {a_r[W-1], a_r} + {b_r[W-1], b_r};
    diff_s = {a_r[W-1], a_r} - {b_r[W-1], b_r};
    prod_s = {{W{a_r[W-1]}}, a_r} * {{W{b_r[W-1]}}, b_r};
    rnd_s  = prod_s + ROUND_WIDE;
    case (op_r)
      OP_ADD:  exec_s = {{(WW-W-1){sum_s[W]}}, sum_s};
      OP_SUB:  exec_s = {{(WW-W-1){diff_s[W]}}, diff_s};
      OP_MUL:  exec_s = rnd_s >>> FRAC_W;
      default: exec_s = a_r[W-1] ? MIN_WIDE : MAX_WIDE;
    endcase
    // Remainder stays below the divisor, so the shifted value always fits W+1 bits.
    shift_s   = {rem_r, quo_r[DIV_ITERS-1]};
    ge_s      = (shift_s >= {1'b0, div_r});
    rem_nxt_s = ge_s ? (shift_s[W-1:0] - div_r) : shift_s[W-1:0];
    quo_ext_s = {{(WW-DIV_ITERS){1'b0}}, quo_r};
    div_res_s = neg_r ? -quo_ext_s : quo_ext_s;
    clip_s    = clip(wide_r);
  end

  // Operand capture, divider iteration and result/flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r     <= 2'b00;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      result_r <= {W{1'b0}};
      sat_r    <= 1'b0;
      dz_r     <= 1'b0;
      wide_r   <= {WW{1'b0}};
      rem_r    <= {W{1'b0}};
      div_r    <= {W{1'b0}};
      quo_r    <= {DIV_ITERS{1'b0}};
      neg_r    <= 1'b0;
      iter_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r   <= op;
            a_r    <= a;
            b_r    <= b;
            sat_r  <= 1'b0;
            dz_r   <= 1'b0;
            rem_r  <= {W{1'b0}};
            quo_r  <= {mag(a), {FRAC_W{1'b0}}};
            div_r  <= mag(b);
            neg_r  <= a[W-1] ^ b[W-1];
            iter_r <= {CNT_W{1'b0}};
          end
        end
        S_EXEC: begin
          wide_r <= exec_s;
          dz_r   <= (op_r == OP_DIV);
        end
        S_DIV: begin
          if (iter_r == LAST_ITER) begin
            wide_r <= div_res_s;
          end else begin
            rem_r  <= rem_nxt_s;
            quo_r  <= {quo_r[DIV_ITERS-2:0], ge_s};
            iter_r <= iter_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_SAT: begin
          result_r <= clip_s[W-1:0];
          sat_r    <= clip_s[W] | dz_r;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_seq_arith_unit.sv
// Scoreboard bench for fxp_seq_arith_unit: directed cases plus random traffic,
// expectations from a plain-arithmetic reference model.
module tb_fxp_seq_arith_unit;

  localparam int     W    = 21;
  localparam int     F    = 10;
  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));

  typedef struct {
    longint res;
    bit     s;
    bit     z;
    longint due;
  } exp_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [1:0]          op = 2'b00;
  logic signed [W-1:0] a = '0;
  logic signed [W-1:0] b = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] result;
  logic                sat;
  logic                dz;

  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc = 0;
  bit     rnd_ready = 1'b0;
  bit     have_cur = 1'b0;
  exp_t   cur;
  exp_t   exp_q[$];

  fxp_seq_arith_unit #(.INT_W(11), .FRAC_W(10)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat), .dz(dz)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: exact rational arithmetic, then round/truncate and clip.
  function automatic exp_t model(input logic [1:0] o, input longint x, input longint y, input longint k);
    exp_t   e;
    longint v;
    longint q;
    e.s = 1'b0;
    e.z = 1'b0;
    e.due = k + 2;
    case (o)
      2'd0: v = x + y;
      2'd1: v = x - y;
      2'd2: v = (x * y + (longint'(1) <<< (F-1))) >>> F;
      default: begin
        if (y == 0) begin
          e.z = 1'b1;
          e.s = 1'b1;
          v = (x >= 0) ? MAXV : MINV;
        end else begin
          q = ((x < 0 ? -x : x) * (longint'(1) <<< F)) / (y < 0 ? -y : y);
          v = ((x < 0) != (y < 0)) ? -q : q;
          e.due = k + W + F + 2;
        end
      end
    endcase
    if (v > MAXV) begin
      v = MAXV;
      e.s = 1'b1;
    end else if (v < MINV) begin
      v = MINV;
      e.s = 1'b1;
    end
    e.res = v;
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    int guard = 0;
    while (!in_ready && guard < 300) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clock); #1;
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles", guard);
    end else begin
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      exp_q.push_back(model(o, x, y, cyc));
    end
  endtask

  // Monitor: pop on first valid cycle, then require the result to hold until taken.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        have_cur = 1'b0;
      end else if (out_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_result: actual %0d required no output", result);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("latency", cyc, cur.due);
            chk("result", result, cur.res);
            chk("sat", sat, longint'(cur.s));
            chk("dz", dz, longint'(cur.z));
          end
        end else begin
          chk("hold_result", result, cur.res);
          chk("hold_sat", sat, longint'(cur.s));
          chk("hold_dz", dz, longint'(cur.z));
        end
        if (out_ready) have_cur = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    logic [31:0] r32;
    logic signed [W-1:0] x, y;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sat", sat, 0);
    chk("rst_dz", dz, 0);

    issue(2'd2, 21'sd3584, -21'sd2304);
    issue(2'd3, 21'sd1024, 21'sd3072);
    for (int i = 0; i < 32; i++) begin
      chk("in_ready_div", in_ready, 0);
      @(posedge clock); #1;
    end
    issue(2'd3, -21'sd1024, 21'sd3072);
    issue(2'd3, -21'sd5120, 21'sd0);
    issue(2'd3, 21'sd0, 21'sd0);
    issue(2'd0, 21'sd1024000, 21'sd102400);
    issue(2'd1, -21'sd1048576, 21'sd1024);
    issue(2'd1, 21'sd5120, 21'sd1024);
    issue(2'd3, -21'sd1048576, -21'sd1024);
    issue(2'd3, -21'sd1048576, 21'sd1024);
    issue(2'd2, -21'sd1048576, -21'sd1048576);

    // Held result with a stalled consumer and stray requests.
    guard = 0;
    while (in_ready == 1'b0 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    out_ready = 1'b0;
    issue(2'd2, 21'sd1536, 21'sd2560);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("stall_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op = 2'd0; a = 21'sd7; b = 21'sd9;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);

    // Reset in the middle of a division.
    issue(2'd3, 21'sd5000, 21'sd7);
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_result", result, 0);
    issue(2'd2, 21'sd1024, 21'sd1024);

    // Random traffic with a randomly stalling consumer.
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r32 = $urandom();
      x = r32[W-1:0];
      x = x >>> $urandom_range(0, 14);
      r32 = $urandom();
      y = r32[W-1:0];
      y = y >>> $urandom_range(0, 14);
      if ($urandom_range(0, 7) == 0) y = '0;
      issue(2'($urandom_range(0, 3)), x, y);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    guard = 0;
    while ((exp_q.size() != 0 || out_valid || have_cur) && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clock); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
